// File: rtl/ex_div.sv
// Multi-cycle restoring radix-2 divider for the execute stage.
// Returns {remainder, quotient} and requests a pipeline stall while busy.
module ex_div #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     dividend,
  input  logic [DATA_W-1:0]     divisor,
  input  logic                  cancel,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready,
  output logic                  stall_req,
  output logic [1:0]            dbg_state
);

  // Handshake: start is a level held by EX until it has consumed the result;
  // ready stays high in END for as long as start stays high, and stall_req
  // covers every cycle in which start is high but ready is not yet.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [2*DATA_W:0]     r_work;
  logic [DATA_W-1:0]     r_dvs;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [2*DATA_W-1:0]   r_result;
  logic                  r_ready;

  logic                  w_dvd_neg;
  logic                  w_dvs_neg;
  logic [DATA_W-1:0]     w_dvd_mag;
  logic [DATA_W-1:0]     w_dvs_mag;
  logic [DATA_W+1:0]     w_diff;
  logic [2*DATA_W:0]     w_step;
  logic [DATA_W-1:0]     w_quo;
  logic [DATA_W-1:0]     w_rem;
  logic [DATA_W-1:0]     w_quo_fix;
  logic [DATA_W-1:0]     w_rem_fix;

  assign w_dvd_neg = signed_div & dividend[DATA_W-1];
  assign w_dvs_neg = signed_div & divisor[DATA_W-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag = w_dvs_neg ? -divisor : divisor;

  // Trial subtract on the shifted-left upper half; the top bit of r_work is
  // always 0, so bit DATA_W+1 of the difference is a reliable sign.
  assign w_diff = r_work[2*DATA_W:DATA_W-1] - {2'b00, r_dvs};
  assign w_step = w_diff[DATA_W+1] ? {r_work[2*DATA_W-1:0], 1'b0}
                                   : {w_diff[DATA_W:0], r_work[DATA_W-2:0], 1'b1};

  assign w_quo     = r_work[DATA_W-1:0];
  assign w_rem     = r_work[2*DATA_W-1:DATA_W];
  assign w_quo_fix = r_neg_q ? -w_quo : w_quo;
  assign w_rem_fix = r_neg_r ? -w_rem : w_rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_work   <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else if (r_state != S_IDLE && cancel) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready  <= 1'b0;
          r_result <= '0;
          if (!cancel && start) begin
            if (divisor == '0) begin
              r_state <= S_BY_ZERO;
            end else begin
              r_work  <= {{(DATA_W+1){1'b0}}, w_dvd_mag};
              r_dvs   <= w_dvs_mag;
              r_neg_q <= w_dvd_neg ^ w_dvs_neg;
              r_neg_r <= w_dvd_neg;
              r_cnt   <= '0;
              r_state <= S_ON;
            end
          end
        end
        S_BY_ZERO: begin
          r_result <= '0;
          r_ready  <= 1'b1;
          r_state  <= S_END;
        end
        S_ON: begin
          if (r_cnt == CNT_W'(DATA_W)) begin
            r_result <= {w_rem_fix, w_quo_fix};
            r_ready  <= 1'b1;
            r_state  <= S_END;
          end else begin
            r_work <= w_step;
            r_cnt  <= r_cnt + CNT_W'(1);
          end
        end
        S_END: begin
          if (!start) begin
            r_ready  <= 1'b0;
            r_result <= '0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result    = r_result;
  assign ready     = r_ready;
  assign stall_req = reset & start & ~r_ready & ~cancel;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: hand-computed divide results, stall and latency
// counts, divide by zero, cancel and asynchronous reset.
module tb_ex_div;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_err;

  ex_div #(.DATA_W(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .signed_div (signed_div),
    .dividend   (dividend),
    .divisor    (divisor),
    .cancel     (cancel),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full divide transaction: raise start, count edges and stall cycles until
  // ready, check the result, hold one cycle, then release and check clear.
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int exp_edges, input int exp_stall, input logic scramble);
    int   edges;
    int   stalls;
    logic done;
    edges  = 0;
    stalls = 0;
    done   = 1'b0;
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = sd;
    dividend   = a;
    divisor    = b;
    @(negedge clk);
    check({tag, "_stall_pre"}, {63'd0, stall_req}, 64'd1);
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      edges++;
      if (scramble && edges == 5) begin
        #1;
        dividend   = 32'hDEADBEEF;
        divisor    = 32'h00000000;
        signed_div = ~signed_div;
      end
      @(negedge clk);
      if (ready) done = 1'b1;
      else if (stall_req) stalls++;
    end
    check({tag, "_timeout"}, {63'd0, done}, 64'd1);
    check({tag, "_edges"}, 64'(edges), 64'(exp_edges));
    check({tag, "_stalls"}, 64'(stalls), 64'(exp_stall));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_stall_done"}, {63'd0, stall_req}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_hold_ready"}, {63'd0, ready}, 64'd1);
    check({tag, "_hold_result"}, result, exp_res);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rel_ready"}, {63'd0, ready}, 64'd0);
    check({tag, "_rel_result"}, result, 64'd0);
    check({tag, "_rel_state"}, {62'd0, dbg_state}, 64'd0);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    dividend   = 32'd0;
    divisor    = 32'd0;
    cancel     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_stall", {63'd0, stall_req}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    start = 1'b1;
    #1;
    check("rst_stall_start", {63'd0, stall_req}, 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Main divide vectors
    run_div("u100d7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 33, 1'b0);
    run_div("s_m7d2", 1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 33, 1'b0);
    run_div("u_m7d2", 1'b0, 32'hFFFFFFF9, 32'h2, {32'h00000001, 32'h7FFFFFFC}, 34, 33, 1'b0);
    run_div("s7dm2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 34, 33, 1'b0);
    run_div("sm100dm7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}, 34, 33, 1'b0);
    run_div("divzero", 1'b0, 32'h12345678, 32'h0, 64'd0, 2, 1, 1'b0);
    run_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34, 33, 1'b0);
    run_div("u_max", 1'b0, 32'hFFFFFFFF, 32'h1, {32'h0, 32'hFFFFFFFF}, 34, 33, 1'b0);
    run_div("scramble", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 34, 33, 1'b1);

    // Cancel with start in IDLE: stays idle, no stall
    @(posedge clk); #1;
    start    = 1'b1;
    cancel   = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(negedge clk);
    check("idle_cancel_stall", {63'd0, stall_req}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle_cancel_state", {62'd0, dbg_state}, 64'd0);
    start  = 1'b0;
    cancel = 1'b0;

    // Cancel pulse at cycle 10 of ON, then a fresh divide
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    cancel = 1'b1;
    #1;
    check("cancel_stall", {63'd0, stall_req}, 64'd0);
    @(posedge clk); #1;
    cancel = 1'b0;
    start  = 1'b0;
    @(negedge clk);
    check("cancel_ready", {63'd0, ready}, 64'd0);
    check("cancel_result", result, 64'd0);
    check("cancel_state", {62'd0, dbg_state}, 64'd0);
    run_div("after_cancel", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 33, 1'b0);

    // Asynchronous reset mid-ON
    @(posedge clk); #1;
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    repeat (6) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_on_ready", {63'd0, ready}, 64'd0);
    check("arst_on_result", result, 64'd0);
    check("arst_on_stall", {63'd0, stall_req}, 64'd0);
    check("arst_on_state", {62'd0, dbg_state}, 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Asynchronous reset while a result is held in END
    @(posedge clk); #1;
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("end_ready", {63'd0, ready}, 64'd1);
    check("end_result", result, {32'd2, 32'd14});
    #2;
    reset = 1'b0;
    #1;
    check("arst_end_ready", {63'd0, ready}, 64'd0);
    check("arst_end_result", result, 64'd0);
    check("arst_end_stall", {63'd0, stall_req}, 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    run_div("post_reset", 1'b1, 32'hFFFFFFF7, 32'd3, {32'd0, 32'hFFFFFFFD}, 34, 33, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
